// File: rtl/mtr_drv_if.sv
// Speed-in / H-bridge-out bundle between the PID block (master) and mtr_drv (slave).
interface mtr_drv_if;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lftPWM1;
    logic               lftPWM2;
    logic               rghtPWM1;
    logic               rghtPWM2;
    logic               prd_done;

    modport master (
        output lft_spd, rght_spd,
        input  lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_done
    );

    modport slave (
        input  lft_spd, rght_spd,
        output lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_done
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual-side 11-bit PWM H-bridge driver with complementary legs and dead time.
// Optional SLEW_LIMIT_EN: duty moves toward target by at most MAX_STEP per period.
module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int MAX_STEP   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    mtr_drv_if.slave   bus
);

    localparam logic [10:0] CNT_LAST  = 11'h7FF;
    localparam logic [10:0] DUTY_MID  = 11'h400;
    localparam logic [7:0]  DT_MAX    = 8'(NONOVERLAP);

    logic [10:0]        cnt_q, cnt_d;
    logic signed [10:0] spd        [2];
    logic [10:0]        duty_tgt   [2];
    logic [10:0]        duty_q     [2];
    logic [10:0]        duty_d     [2];
    logic               raw        [2];
    logic               raw_prev_q [2];
    logic               raw_prev_d [2];
    logic [7:0]         dt_q       [2];
    logic [7:0]         dt_d       [2];
    logic               pwm1_q     [2];
    logic               pwm1_d     [2];
    logic               pwm2_q     [2];
    logic               pwm2_d     [2];

`ifdef SLEW_LIMIT_EN
    localparam logic signed [11:0] STEP_S = 12'(MAX_STEP);

    // Moves toward tgt without overshoot, so the result stays inside 0..2047.
    function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic [10:0] tgt);
        logic signed [11:0] cur_s;
        logic signed [11:0] tgt_s;
        logic signed [11:0] diff;
        logic signed [11:0] res;
        cur_s = signed'({1'b0, cur});
        tgt_s = signed'({1'b0, tgt});
        diff  = tgt_s - cur_s;
        if (diff > STEP_S)
            res = cur_s + STEP_S;
        else if (diff < -STEP_S)
            res = cur_s - STEP_S;
        else
            res = tgt_s;
        return res[10:0];
    endfunction
`endif

    assign spd[0] = bus.lft_spd;
    assign spd[1] = bus.rght_spd;

    always_comb begin
        cnt_d = cnt_q + 11'd1;
        for (int s = 0; s < 2; s++) begin
            // Offset-binary: flipping the sign bit maps -1024..1023 onto 0..2047.
            duty_tgt[s]   = {~spd[s][10], spd[s][9:0]};
            duty_d[s]     = duty_q[s];
            if (cnt_q == CNT_LAST) begin
`ifdef SLEW_LIMIT_EN
                duty_d[s] = slew_step(duty_q[s], duty_tgt[s]);
`else
                duty_d[s] = duty_tgt[s];
`endif
            end
            raw[s]        = (cnt_q < duty_q[s]);
            raw_prev_d[s] = raw[s];
            // Dead time restarts in the very cycle raw toggles, so neither leg fires at the edge.
            if (raw[s] != raw_prev_q[s])
                dt_d[s] = 8'd0;
            else if (dt_q[s] == DT_MAX)
                dt_d[s] = DT_MAX;
            else
                dt_d[s] = dt_q[s] + 8'd1;
            pwm1_d[s]     =  raw[s] & (dt_d[s] == DT_MAX);
            pwm2_d[s]     = ~raw[s] & (dt_d[s] == DT_MAX);
        end
    end

    // raw_prev resets low: raw is high at cnt 0 with mid duty, so release counts as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 11'd0;
            for (int s = 0; s < 2; s++) begin
                duty_q[s]     <= DUTY_MID;
                raw_prev_q[s] <= 1'b0;
                dt_q[s]       <= 8'd0;
                pwm1_q[s]     <= 1'b0;
                pwm2_q[s]     <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int s = 0; s < 2; s++) begin
                duty_q[s]     <= duty_d[s];
                raw_prev_q[s] <= raw_prev_d[s];
                dt_q[s]       <= dt_d[s];
                pwm1_q[s]     <= pwm1_d[s];
                pwm2_q[s]     <= pwm2_d[s];
            end
        end
    end

    assign bus.lftPWM1  = pwm1_q[0];
    assign bus.lftPWM2  = pwm2_q[0];
    assign bus.rghtPWM1 = pwm1_q[1];
    assign bus.rghtPWM2 = pwm2_q[1];
    assign bus.prd_done = rst_n & (cnt_q == CNT_LAST);

endmodule
